// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, then stop time, no parity.
// The line only moves when i_tick pulses. The pin is a register.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int NUM_TICKS  = 16,
   parameter int STOP_TICKS = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_tx_start,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_tx_done
);

   localparam int MAX_TICKS = (NUM_TICKS > STOP_TICKS) ? NUM_TICKS : STOP_TICKS;
   localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(NUM_TICKS - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;

   // Handshake: a request is taken only in IDLE and never during the o_tx_done cycle.
   // o_busy rises on the cycle after acceptance. Requests made while busy are dropped.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         o_tx      <= 1'b1;
         o_busy    <= 1'b0;
         o_tx_done <= 1'b0;
      end else begin
         o_tx_done <= 1'b0;
         case (state)
            IDLE: begin
               o_tx <= 1'b1;
               if (i_tx_start && !o_tx_done) begin
                  shreg    <= i_data;
                  tick_cnt <= '0;
                  o_busy   <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               o_tx <= 1'b0;
               if (i_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               o_tx <= shreg[0];
               if (i_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     shreg    <= shreg >> 1;
                     tick_cnt <= '0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               o_tx <= 1'b1;
               if (i_tick) begin
                  if (tick_cnt == STOP_LAST) begin
                     tick_cnt  <= '0;
                     o_busy    <= 1'b0;
                     o_tx_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Ticks arrive every 4 clocks.
// Line levels are checked at the middle of each bit, counted in ticks after acceptance.
module tb_uart_tx;

   logic       i_clock;
   logic       i_reset;
   logic       i_tick;
   logic       i_tx_start;
   logic [7:0] i_data;
   logic       o_tx;
   logic       o_busy;
   logic       o_tx_done;

   int   passed     = 0;
   int   total      = 0;
   int   ticks_seen = 0;
   int   done_cnt   = 0;
   int   div        = 0;
   logic tick_en    = 1'b0;

   localparam int M_PLAIN = 0;
   localparam int M_BUSY  = 1;
   localparam int M_STALL = 2;
   localparam int M_B2B   = 3;

   uart_tx #(.DATA_BITS(8), .NUM_TICKS(16), .STOP_TICKS(16)) dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_tick     (i_tick),
      .i_tx_start (i_tx_start),
      .i_data     (i_data),
      .o_tx       (o_tx),
      .o_busy     (o_busy),
      .o_tx_done  (o_tx_done)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: sample just after the edge, then set up the tick for the next edge.
   task automatic cycle();
      logic t;
      t = i_tick;
      @(posedge i_clock);
      #1;
      if (t) ticks_seen++;
      if (o_tx_done === 1'b1) done_cnt++;
      if (tick_en) begin
         div    = (div == 3) ? 0 : div + 1;
         i_tick = (div == 0);
      end else begin
         i_tick = 1'b0;
      end
   endtask

   task automatic wait_ticks(input int target);
      int n;
      n = 0;
      while (ticks_seen < target && n < 2000) begin
         cycle();
         n++;
      end
      chk($sformatf("tick_wait_%0d", target), (ticks_seen >= target), 1);
   endtask

   task automatic accept();
      cycle();
      ticks_seen = 0;
      done_cnt   = 0;
      i_tx_start = 1'b0;
      chk("accept_busy", o_busy, 1);
      chk("accept_tx_still_high", o_tx, 1);
      cycle();
      chk("start_fall", o_tx, 0);
   endtask

   task automatic send(input logic [7:0] data);
      i_data     = data;
      i_tx_start = 1'b1;
      accept();
   endtask

   // exp[0] is the start bit, exp[8:1] the data bits in line order, and exp[9] the stop bit.
   task automatic check_frame(input logic [9:0] exp, input int mode);
      int   changes;
      logic level;
      for (int b = 0; b < 10; b++) begin
         if (mode == M_BUSY && b == 3) begin
            wait_ticks(50);
            i_tx_start = 1'b1;
            i_data     = 8'hFF;
            cycle();
            i_tx_start = 1'b0;
            i_data     = 8'h00;
         end
         wait_ticks(16 * b + 8);
         chk($sformatf("bit%0d", b), o_tx, exp[b]);
         chk($sformatf("busy_bit%0d", b), o_busy, 1);
         if (mode == M_STALL && b == 4) begin
            tick_en = 1'b0;
            i_tick  = 1'b0;
            level   = o_tx;
            changes = 0;
            repeat (100) begin
               cycle();
               if (o_tx !== level || o_busy !== 1'b1) changes++;
            end
            chk("stall_hold", changes, 0);
            tick_en = 1'b1;
         end
         if (mode == M_B2B && b == 9) begin
            i_tx_start = 1'b1;
            i_data     = 8'hFF;
         end
      end
      wait_ticks(160);
      chk("done_pulse", o_tx_done, 1);
      chk("done_busy_low", o_busy, 0);
      chk("done_tx_high", o_tx, 1);
      chk("done_count", done_cnt, 1);
   endtask

   initial begin
      int bad;
      int lows;
      int n;
      i_reset    = 1'b0;
      i_tick     = 1'b0;
      i_tx_start = 1'b0;
      i_data     = 8'h00;
      tick_en    = 1'b1;
      div        = 0;

      // Reset, then idle with no request
      repeat (5) cycle();
      chk("reset_tx", o_tx, 1);
      chk("reset_busy", o_busy, 0);
      chk("reset_done", o_tx_done, 0);
      i_reset = 1'b1;
      bad = 0;
      repeat (200) begin
         cycle();
         if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
      end
      chk("idle_after_reset", bad, 0);

      // Single frame of 8'hA5
      send(8'hA5);
      check_frame(10'b1_10100101_0, M_PLAIN);
      repeat (5) cycle();
      chk("a5_single_done", done_cnt, 1);

      // A request during the frame and a change of i_data are both ignored
      send(8'h3C);
      check_frame(10'b1_00111100_0, M_BUSY);
      bad = 0;
      repeat (200) begin
         cycle();
         if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
      end
      chk("no_second_frame", bad, 0);
      chk("busy_test_done_count", done_cnt, 1);

      // Back-to-back frames with the request held across o_tx_done
      send(8'h00);
      check_frame(10'b1_00000000_0, M_B2B);
      cycle();
      chk("b2b_gap_busy", o_busy, 0);
      chk("b2b_gap_tx", o_tx, 1);
      accept();
      check_frame(10'b1_11111111_0, M_PLAIN);
      repeat (5) cycle();

      // Reset during data bit 3 of 8'h55
      send(8'h55);
      wait_ticks(72);
      chk("pre_reset_bit3", o_tx, 0);
      i_reset = 1'b0;
      #1;
      chk("midreset_tx", o_tx, 1);
      chk("midreset_busy", o_busy, 0);
      chk("midreset_done", o_tx_done, 0);
      done_cnt = 0;
      repeat (3) cycle();
      i_reset = 1'b1;
      repeat (10) cycle();
      chk("midreset_no_done", done_cnt, 0);
      chk("midreset_idle_tx", o_tx, 1);
      send(8'h81);
      check_frame(10'b1_10000001_0, M_PLAIN);

      // Ticks stop for 100 clocks during the data bits
      repeat (3) cycle();
      send(8'h96);
      check_frame(10'b1_10010110_0, M_STALL);

      // A tick on the accepting edge does not count toward the start bit
      repeat (3) cycle();
      i_data     = 8'hC3;
      i_tx_start = 1'b1;
      div        = 0;
      i_tick     = 1'b1;
      accept();
      lows = 1;
      n    = 0;
      while (o_tx === 1'b0 && n < 200) begin
         cycle();
         n++;
         if (o_tx === 1'b0) lows++;
      end
      chk("start_bit_clocks", lows, 64);
      wait_ticks(160);
      chk("coinc_done", o_tx_done, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
